trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Upstream sequencer for the machine-mode CSR file. Collects per-instruction exception and mret indications from decode/execute and selects one cause by priority.
- Runs a small FSM that stalls and flushes the pipeline, drives the single-cycle trap-entry or mret strobe into the CSR file, then redirects fetch to mtvec or mepc.
- Owns the RISC-V cause/tval encoding so the CSR file only latches values.

Parameters:
- XLEN, 32, data/address width.
- CNT_W, 16, width of the saturating trap counter.

Ports:
- clk  in  1  system clock; FSM updates on rising edge.
- reset_x  in  1  asynchronous active-low reset.
- inst_valid  in  1  decode/execute holds a valid instruction this cycle.
- pc  in  XLEN  PC of that instruction.
- inst  in  32  raw instruction bits.
- fetch_addr  in  XLEN  branch/jump target that was misaligned.
- mem_addr  in  XLEN  load/store effective address.
- exc_inst_misaligned  in  1  target fetch address misaligned.
- exc_illegal  in  1  illegal instruction.
- exc_ebreak  in  1  ebreak.
- exc_ecall  in  1  ecall.
- exc_store_misaligned  in  1  store address misaligned.
- exc_load_misaligned  in  1  load address misaligned.
- mret_inst  in  1  mret decoded.
- priv_mode  in  2  current privilege (00 U, 11 M).
- mtvec  in  XLEN  current mtvec.
- mepc  in  XLEN  current mepc.
- exception_o  out  1  trap-entry strobe to CSR file.
- mret_o  out  1  mret strobe to CSR file.
- mcause_o  out  4  exception code.
- mepc_o  out  XLEN  faulting PC.
- mtval_o  out  XLEN  trap value.
- stall  out  1  freeze pipeline front end.
- flush  out  1  kill younger instructions.
- redirect_valid  out  1  fetch must load redirect_pc.
- redirect_pc  out  XLEN  new fetch address.
- trap_count  out  CNT_W  number of exception entries taken.

Behaviour:
- Reset (async, reset_x=0): state IDLE. All strobes, stall, flush, redirect_valid = 0. mcause_o, mepc_o, mtval_o, redirect_pc, trap_count = 0. Reset mid-sequence aborts the sequence with no strobe.
- Cause priority (highest first), evaluated only in IDLE with inst_valid=1:
  - inst_misaligned: cause 0, tval = fetch_addr.
  - illegal: cause 2, tval = inst.
  - mret with priv_mode != 11: cause 2, tval = inst.
  - ebreak: cause 3, tval = pc.
  - ecall: cause 8 if priv_mode = 00, cause 11 if priv_mode = 11; tval = 0.
  - store_misaligned: cause 6, tval = mem_addr.
  - load_misaligned: cause 4, tval = mem_addr.
- FSM states: IDLE, TRAP_ENTER, MRET_EXEC, REDIRECT.
- IDLE:
  - Any selected exception: register cause, pc into mepc_o and tval; go to TRAP_ENTER.
  - Else legal mret (priv_mode = 11): go to MRET_EXEC.
  - Exception always beats mret in the same cycle.
  - Outputs are 0 in IDLE.
- TRAP_ENTER, exactly 1 cycle:
  - exception_o=1, stall=1, flush=1.
  - mcause_o/mepc_o/mtval_o stable for the whole cycle, since the CSR file samples on the falling edge.
  - trap_count += 1, saturating at all-ones.
  - Redirect target registered as {mtvec[XLEN-1:2], 2'b00}; exceptions ignore vectored mode.
  - Next state REDIRECT.
- MRET_EXEC, 1 cycle:
  - mret_o=1, stall=1, flush=1.
  - Redirect target registered as {mepc[XLEN-1:2], 2'b00}, sampled before the CSR update.
  - Next state REDIRECT.
- REDIRECT, 1 cycle:
  - redirect_valid=1, stall=1, flush=1, redirect_pc = registered target.
  - Next state IDLE.
- Latency: faulting/mret instruction seen in cycle N → strobe in N+1 → redirect in N+2 → new instruction accepted in IDLE at N+3.
- Inputs are ignored outside IDLE; stall guarantees they are held or killed.
- exception_o and mret_o are never high together; each is a single-cycle pulse.
- cause/mepc/tval outputs hold their last values until the next trap.

Test Plan:
- Reset then idle with inst_valid=0 → all outputs 0 and state IDLE for 10 cycles.
- exc_illegal=1, pc=0x100, inst=0xFFFFFFFF, mtvec=0x203 → N+1: exception_o=1, mcause_o=2, mepc_o=0x100, mtval_o=0xFFFFFFFF; N+2: redirect_valid=1, redirect_pc=0x200; trap_count=1.
- exc_ecall=1 together with exc_load_misaligned=1, priv_mode=00 → mcause_o=8, mtval_o=0; repeat with priv_mode=11 → mcause_o=11.
- mret_inst=1, priv_mode=11, mepc=0x1236 → N+1: mret_o=1, exception_o=0; N+2: redirect_pc=0x1234; mret_inst with priv_mode=00 → exception_o=1, mcause_o=2.
- exc_inst_misaligned + exc_illegal + mret_inst in the same cycle, fetch_addr=0x82 → mcause_o=0, mtval_o=0x82, no mret_o; new exceptions during REDIRECT produce no extra strobe.
- reset_x low during TRAP_ENTER → exception_o drops immediately, state IDLE; 2^CNT_W+1 traps → trap_count saturates at all-ones.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: selects one exception cause by priority and sequences the
// stall/flush, CSR strobe and fetch redirect for trap entry and mret.
module trap_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_x,
  input  logic             inst_valid,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  fetch_addr,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic             exc_inst_misaligned,
  input  logic             exc_illegal,
  input  logic             exc_ebreak,
  input  logic             exc_ecall,
  input  logic             exc_store_misaligned,
  input  logic             exc_load_misaligned,
  input  logic             mret_inst,
  input  logic [1:0]       priv_mode,
  input  logic [XLEN-1:0]  mtvec,
  input  logic [XLEN-1:0]  mepc,
  output logic             exception_o,
  output logic             mret_o,
  output logic [3:0]       mcause_o,
  output logic [XLEN-1:0]  mepc_o,
  output logic [XLEN-1:0]  mtval_o,
  output logic             stall,
  output logic             flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] trap_count
);

  typedef enum logic [1:0] {IDLE, TRAP_ENTER, MRET_EXEC, REDIRECT} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cause_d, mcause_q;
  logic [XLEN-1:0]   tval_d, mtval_q, mepc_q, rpc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              exc_hit, mret_ok, m_mode;

  assign m_mode  = (priv_mode == 2'b11);
  assign mret_ok = mret_inst && m_mode;

  // Priority encode the exception sources into cause/tval.
  always_comb begin
    exc_hit = 1'b1;
    cause_d = 4'd0;
    tval_d  = '0;
    if (exc_inst_misaligned) begin
      cause_d = 4'd0;
      tval_d  = fetch_addr;
    end else if (exc_illegal || (mret_inst && !m_mode)) begin
      cause_d = 4'd2;
      tval_d  = XLEN'(inst);
    end else if (exc_ebreak) begin
      cause_d = 4'd3;
      tval_d  = pc;
    end else if (exc_ecall) begin
      // Environment call code is 8 plus the privilege level (U=8, M=11).
      cause_d = 4'd8 + {2'b00, priv_mode};
    end else if (exc_store_misaligned) begin
      cause_d = 4'd6;
      tval_d  = mem_addr;
    end else if (exc_load_misaligned) begin
      cause_d = 4'd4;
      tval_d  = mem_addr;
    end else begin
      exc_hit = 1'b0;
    end
  end

  // Next-state and strobe decode; inputs only matter in IDLE.
  always_comb begin
    state_d        = state_q;
    exception_o    = 1'b0;
    mret_o         = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (inst_valid) begin
          if (exc_hit)      state_d = TRAP_ENTER;
          else if (mret_ok) state_d = MRET_EXEC;
        end
      end
      TRAP_ENTER: begin
        exception_o = 1'b1;
        stall       = 1'b1;
        flush       = 1'b1;
        state_d     = REDIRECT;
      end
      MRET_EXEC: begin
        mret_o  = 1'b1;
        stall   = 1'b1;
        flush   = 1'b1;
        state_d = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        stall          = 1'b1;
        flush          = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Capture trap info on entry; held until the next trap.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      mcause_q <= 4'd0;
      mepc_q   <= '0;
      mtval_q  <= '0;
    end else if (state_q == IDLE && inst_valid && exc_hit) begin
      mcause_q <= cause_d;
      mepc_q   <= pc;
      mtval_q  <= tval_d;
    end
  end

  // Redirect target: mtvec base (vectored mode ignored) or mepc sampled
  // before the CSR file applies the mret update; trap counter saturates.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      rpc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == TRAP_ENTER) begin
      rpc_q <= {mtvec[XLEN-1:2], 2'b00};
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end else if (state_q == MRET_EXEC) begin
      rpc_q <= {mepc[XLEN-1:2], 2'b00};
    end
  end

  assign mcause_o    = mcause_q;
  assign mepc_o      = mepc_q;
  assign mtval_o     = mtval_q;
  assign redirect_pc = rpc_q;
  assign trap_count  = cnt_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected strobe/cause/redirect results are
// queued when an instruction is driven and compared when the strobe appears.
module tb_trap_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0, reset_x = 1'b0;
  logic inst_valid;
  logic [XLEN-1:0] pc, fetch_addr, mem_addr, mtvec, mepc;
  logic [31:0] inst;
  logic exc_inst_misaligned, exc_illegal, exc_ebreak, exc_ecall;
  logic exc_store_misaligned, exc_load_misaligned, mret_inst;
  logic [1:0] priv_mode;
  logic exception_o, mret_o, stall, flush, redirect_valid;
  logic [3:0] mcause_o;
  logic [XLEN-1:0] mepc_o, mtval_o, redirect_pc;
  logic [CNT_W-1:0] trap_count;

  trap_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_x(reset_x), .inst_valid(inst_valid), .pc(pc), .inst(inst),
    .fetch_addr(fetch_addr), .mem_addr(mem_addr),
    .exc_inst_misaligned(exc_inst_misaligned), .exc_illegal(exc_illegal),
    .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall),
    .exc_store_misaligned(exc_store_misaligned), .exc_load_misaligned(exc_load_misaligned),
    .mret_inst(mret_inst), .priv_mode(priv_mode), .mtvec(mtvec), .mepc(mepc),
    .exception_o(exception_o), .mret_o(mret_o), .mcause_o(mcause_o), .mepc_o(mepc_o),
    .mtval_o(mtval_o), .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_count(trap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              is_exc;
    logic [3:0]      cause;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] tval;
    logic [XLEN-1:0] rpc;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    inst_valid = 0; exc_inst_misaligned = 0; exc_illegal = 0; exc_ebreak = 0;
    exc_ecall = 0; exc_store_misaligned = 0; exc_load_misaligned = 0; mret_inst = 0;
  endtask

  task automatic push(input bit is_exc, input logic [3:0] cause, input logic [XLEN-1:0] epc,
                      input logic [XLEN-1:0] tval, input logic [XLEN-1:0] rpc);
    exp_t e;
    e.is_exc = is_exc; e.cause = cause; e.epc = epc; e.tval = tval; e.rpc = rpc;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the strobe, then check strobe, redirect and return to IDLE.
  // hold keeps the instruction inputs asserted through the strobe and redirect cycles.
  task automatic run(input bit hold);
    exp_t e;
    bit got = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!hold) clr();
      if (exception_o || mret_o) begin got = 1; break; end
    end
    if (!got) chk("strobe_timeout", 0, 1);
    e = sb.pop_front();
    chk("exception_o", exception_o, e.is_exc);
    chk("mret_o", mret_o, !e.is_exc);
    chk("strobe_stall_flush", {stall, flush}, 2'b11);
    if (e.is_exc) begin
      if (exp_cnt != '1) exp_cnt++;
      chk("mcause_o", mcause_o, e.cause);
      chk("mepc_o", mepc_o, e.epc);
      chk("mtval_o", mtval_o, e.tval);
    end
    tick();
    chk("redirect_valid", redirect_valid, 1);
    chk("redirect_pc", redirect_pc, e.rpc);
    chk("trap_count", trap_count, exp_cnt);
    chk("redir_no_strobe", {exception_o, mret_o}, 2'b00);
    chk("redir_stall_flush", {stall, flush}, 2'b11);
    clr();
    tick();
    chk("idle_outs", {exception_o, mret_o, stall, flush, redirect_valid}, 5'b0);
    tick();
    chk("idle_no_extra", {exception_o, mret_o, stall}, 3'b0);
  endtask

  initial begin
    clr();
    pc = '0; inst = '0; fetch_addr = '0; mem_addr = '0; priv_mode = 2'b11;
    mtvec = 32'h203; mepc = '0;
    repeat (3) tick();
    reset_x = 1;

    // Idle after reset: everything zero for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("reset_idle", {exception_o, mret_o, stall, flush, redirect_valid,
                         mcause_o, mepc_o, mtval_o, redirect_pc, trap_count}, '0);
    end

    // Illegal instruction.
    inst_valid = 1; exc_illegal = 1; pc = 32'h100; inst = 32'hFFFF_FFFF;
    push(1, 4'd2, 32'h100, 32'hFFFF_FFFF, 32'h200); run(0);

    // ecall beats load misaligned; cause follows privilege.
    inst_valid = 1; exc_ecall = 1; exc_load_misaligned = 1; priv_mode = 2'b00;
    pc = 32'h300; mem_addr = 32'h1001;
    push(1, 4'd8, 32'h300, 32'h0, 32'h200); run(0);
    inst_valid = 1; exc_ecall = 1; exc_load_misaligned = 1; priv_mode = 2'b11;
    pc = 32'h304;
    push(1, 4'd11, 32'h304, 32'h0, 32'h200); run(0);

    // Legal mret redirects to word-aligned mepc.
    mepc = 32'h1236; inst = 32'h3020_0073; pc = 32'h400;
    inst_valid = 1; mret_inst = 1; priv_mode = 2'b11;
    push(0, 4'd0, 32'h0, 32'h0, 32'h1234); run(0);

    // mret from U-mode is illegal.
    inst_valid = 1; mret_inst = 1; priv_mode = 2'b00; pc = 32'h404;
    push(1, 4'd2, 32'h404, 32'h3020_0073, 32'h200); run(0);

    // Misaligned fetch beats illegal and mret; inputs held through the sequence.
    priv_mode = 2'b11; mtvec = 32'h0000_8001;
    inst_valid = 1; exc_inst_misaligned = 1; exc_illegal = 1; mret_inst = 1;
    fetch_addr = 32'h82; pc = 32'h500;
    push(1, 4'd0, 32'h500, 32'h82, 32'h8000); run(1);

    // Store misaligned, load misaligned, ebreak over store.
    inst_valid = 1; exc_store_misaligned = 1; exc_load_misaligned = 1;
    mem_addr = 32'h1003; pc = 32'h600;
    push(1, 4'd6, 32'h600, 32'h1003, 32'h8000); run(0);
    inst_valid = 1; exc_load_misaligned = 1; mem_addr = 32'h2002; pc = 32'h604;
    push(1, 4'd4, 32'h604, 32'h2002, 32'h8000); run(0);
    inst_valid = 1; exc_ebreak = 1; exc_store_misaligned = 1; pc = 32'h608;
    push(1, 4'd3, 32'h608, 32'h608, 32'h8000); run(0);

    // Reset during TRAP_ENTER aborts with no strobe and clears the counter.
    inst_valid = 1; exc_illegal = 1; pc = 32'h700;
    tick();
    clr();
    chk("pre_reset_exc", exception_o, 1);
    reset_x = 0; #1;
    chk("reset_abort", {exception_o, stall, flush, redirect_valid}, 4'b0);
    chk("reset_count", trap_count, 0);
    tick(); tick();
    reset_x = 1; exp_cnt = '0;
    tick();
    chk("post_reset_idle", {exception_o, mret_o, stall, redirect_valid}, 4'b0);

    // Saturation: 2^CNT_W + 1 traps.
    for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
      inst_valid = 1; exc_ebreak = 1; pc = 32'h900 + 4 * i;
      push(1, 4'd3, 32'h900 + 4 * i, 32'h900 + 4 * i, 32'h8000); run(0);
    end
    chk("count_saturated", trap_count, {CNT_W{1'b1}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
